// File: rtl/vxe_axi4mas_pkg.sv
// Shared AXI4 constants, request FSM encodings and the AxSIZE helper
// for the VxEngine AXI4 master bus interface unit.
package vxe_axi4mas_pkg;

   localparam logic [1:0] BURST_INCR    = 2'b01;

   localparam logic [1:0] RESP_OKAY     = 2'b00;
   localparam logic [1:0] RESP_EXOKAY   = 2'b01;
   localparam logic [1:0] RESP_SLVERR   = 2'b10;
   localparam logic [1:0] RESP_DECERR   = 2'b11;

   localparam logic       LOCK_DEFAULT  = 1'b0;
   localparam logic [3:0] CACHE_DEFAULT = 4'b0000;
   localparam logic [2:0] PROT_DEFAULT  = 3'b000;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   function automatic logic [2:0] axi_size(input int unsigned data_width);
      return 3'($clog2(data_width / 8));
   endfunction

endpackage

// File: rtl/vxe_axi4mas_biu_resp.sv
// Response return path (B or R) from the AXI slave into a client queue.
// VXE_AXI4MAS_BIU_RESP_REG_EN selects a one-entry register instead of pass-through.
module vxe_axi4mas_biu_resp #(
   parameter int unsigned PW = 10
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          s_valid_i,
   input  logic [PW-1:0] s_payload_i,
   output logic          s_ready_o,
   input  logic          c_ready_i,
   output logic          c_push_o,
   output logic [PW-1:0] c_payload_o
);

`ifdef VXE_AXI4MAS_BIU_RESP_REG_EN
   logic          full_q, full_d;
   logic [PW-1:0] data_q, data_d;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (full_q && c_ready_i) full_d = 1'b0;
      if (s_valid_i && !full_q) begin
         full_d = 1'b1;
         data_d = s_payload_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign s_ready_o   = !full_q && !rst_i;
   assign c_push_o    = full_q && c_ready_i && !rst_i;
   assign c_payload_o = data_q;
`else
   logic unused_clk;
   assign unused_clk  = clk_i;

   // Ready is gated by reset so the slave never sees a handshake while in reset.
   assign s_ready_o   = c_ready_i && !rst_i;
   assign c_push_o    = s_valid_i && c_ready_i && !rst_i;
   assign c_payload_o = s_payload_i;
`endif

endmodule

// File: rtl/vxe_axi4mas_biu.sv
// AXI4 master BIU: single-word client write/read requests to single-beat AXI4.
// Define VXE_AXI4MAS_BIU_RESP_REG_EN to register the B and R response paths.
module vxe_axi4mas_biu
   import vxe_axi4mas_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned CID_WIDTH  = 8
) (
   input  logic                    M_AXI4_ACLK,
   input  logic                    M_AXI4_ARESETn,
   output logic [ID_WIDTH-1:0]     M_AXI4_AWID,
   output logic [ADDR_WIDTH-1:0]   M_AXI4_AWADDR,
   output logic [7:0]              M_AXI4_AWLEN,
   output logic [2:0]              M_AXI4_AWSIZE,
   output logic [1:0]              M_AXI4_AWBURST,
   output logic                    M_AXI4_AWLOCK,
   output logic [3:0]              M_AXI4_AWCACHE,
   output logic [2:0]              M_AXI4_AWPROT,
   output logic                    M_AXI4_AWVALID,
   input  logic                    M_AXI4_AWREADY,
   output logic [DATA_WIDTH-1:0]   M_AXI4_WDATA,
   output logic [DATA_WIDTH/8-1:0] M_AXI4_WSTRB,
   output logic                    M_AXI4_WLAST,
   output logic                    M_AXI4_WVALID,
   input  logic                    M_AXI4_WREADY,
   input  logic [ID_WIDTH-1:0]     M_AXI4_BID,
   input  logic [1:0]              M_AXI4_BRESP,
   input  logic                    M_AXI4_BVALID,
   output logic                    M_AXI4_BREADY,
   output logic [ID_WIDTH-1:0]     M_AXI4_ARID,
   output logic [ADDR_WIDTH-1:0]   M_AXI4_ARADDR,
   output logic [7:0]              M_AXI4_ARLEN,
   output logic [2:0]              M_AXI4_ARSIZE,
   output logic [1:0]              M_AXI4_ARBURST,
   output logic                    M_AXI4_ARLOCK,
   output logic [3:0]              M_AXI4_ARCACHE,
   output logic [2:0]              M_AXI4_ARPROT,
   output logic                    M_AXI4_ARVALID,
   input  logic                    M_AXI4_ARREADY,
   input  logic [ID_WIDTH-1:0]     M_AXI4_RID,
   input  logic [DATA_WIDTH-1:0]   M_AXI4_RDATA,
   input  logic [1:0]              M_AXI4_RRESP,
   input  logic                    M_AXI4_RLAST,
   input  logic                    M_AXI4_RVALID,
   output logic                    M_AXI4_RREADY,
   input  logic [CID_WIDTH-1:0]    biu_awcid,
   input  logic [ADDR_WIDTH-1:0]   biu_awaddr,
   input  logic [DATA_WIDTH-1:0]   biu_awdata,
   input  logic [DATA_WIDTH/8-1:0] biu_awstrb,
   input  logic                    biu_awvalid,
   output logic                    biu_awpop,
   output logic [CID_WIDTH-1:0]    biu_bcid,
   output logic [1:0]              biu_bresp,
   input  logic                    biu_bready,
   output logic                    biu_bpush,
   input  logic [CID_WIDTH-1:0]    biu_arcid,
   input  logic [ADDR_WIDTH-1:0]   biu_araddr,
   input  logic                    biu_arvalid,
   output logic                    biu_arpop,
   output logic [CID_WIDTH-1:0]    biu_rcid,
   output logic [DATA_WIDTH-1:0]   biu_rdata,
   output logic [1:0]              biu_rresp,
   input  logic                    biu_rready,
   output logic                    biu_rpush
);

   localparam int unsigned MW = (ID_WIDTH < CID_WIDTH) ? ID_WIDTH : CID_WIDTH;

   logic rst;
   assign rst = M_AXI4_ARESETn;

   logic unused_rlast;
   assign unused_rlast = M_AXI4_RLAST;

   logic [0:0]              wst_q, wst_d;
   logic                    aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
   logic [CID_WIDTH-1:0]    wcid_q, wcid_d;
   logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;

   // AW and W drop independently; BUSY ends once neither is still pending.
   always_comb begin
      wst_d     = wst_q;
      aw_pend_d = aw_pend_q;
      w_pend_d  = w_pend_q;
      wcid_d    = wcid_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      biu_awpop = 1'b0;
      if (wst_q == ST_IDLE) begin
         if (biu_awvalid && !rst) begin
            biu_awpop = 1'b1;
            wcid_d    = biu_awcid;
            waddr_d   = biu_awaddr;
            wdata_d   = biu_awdata;
            wstrb_d   = biu_awstrb;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            wst_d     = ST_BUSY;
         end
      end else begin
         if (M_AXI4_AWREADY) aw_pend_d = 1'b0;
         if (M_AXI4_WREADY)  w_pend_d  = 1'b0;
         if (!aw_pend_d && !w_pend_d) wst_d = ST_IDLE;
      end
   end

   logic [0:0]            rst_q, rst_d;
   logic [CID_WIDTH-1:0]  rcid_q, rcid_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;

   always_comb begin
      rst_d     = rst_q;
      rcid_d    = rcid_q;
      raddr_d   = raddr_q;
      biu_arpop = 1'b0;
      if (rst_q == ST_IDLE) begin
         if (biu_arvalid && !rst) begin
            biu_arpop = 1'b1;
            rcid_d    = biu_arcid;
            raddr_d   = biu_araddr;
            rst_d     = ST_BUSY;
         end
      end else if (M_AXI4_ARREADY) begin
         rst_d = ST_IDLE;
      end
   end

   always_ff @(posedge M_AXI4_ACLK) begin
      if (rst) begin
         wst_q     <= ST_IDLE;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
         wcid_q    <= '0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rst_q     <= ST_IDLE;
         rcid_q    <= '0;
         raddr_q   <= '0;
      end else begin
         wst_q     <= wst_d;
         aw_pend_q <= aw_pend_d;
         w_pend_q  <= w_pend_d;
         wcid_q    <= wcid_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rst_q     <= rst_d;
         rcid_q    <= rcid_d;
         raddr_q   <= raddr_d;
      end
   end

   logic [CID_WIDTH-1:0] bcid_conv, rcid_conv;

   always_comb begin
      M_AXI4_AWID          = '0;
      M_AXI4_AWID[MW-1:0]  = wcid_q[MW-1:0];
      M_AXI4_ARID          = '0;
      M_AXI4_ARID[MW-1:0]  = rcid_q[MW-1:0];
      bcid_conv            = '0;
      bcid_conv[MW-1:0]    = M_AXI4_BID[MW-1:0];
      rcid_conv            = '0;
      rcid_conv[MW-1:0]    = M_AXI4_RID[MW-1:0];
   end

   assign M_AXI4_AWADDR  = waddr_q;
   assign M_AXI4_AWLEN   = 8'd0;
   assign M_AXI4_AWSIZE  = axi_size(DATA_WIDTH);
   assign M_AXI4_AWBURST = BURST_INCR;
   assign M_AXI4_AWLOCK  = LOCK_DEFAULT;
   assign M_AXI4_AWCACHE = CACHE_DEFAULT;
   assign M_AXI4_AWPROT  = PROT_DEFAULT;
   assign M_AXI4_AWVALID = aw_pend_q;
   assign M_AXI4_WDATA   = wdata_q;
   assign M_AXI4_WSTRB   = wstrb_q;
   assign M_AXI4_WLAST   = 1'b1;
   assign M_AXI4_WVALID  = w_pend_q;

   assign M_AXI4_ARADDR  = raddr_q;
   assign M_AXI4_ARLEN   = 8'd0;
   assign M_AXI4_ARSIZE  = axi_size(DATA_WIDTH);
   assign M_AXI4_ARBURST = BURST_INCR;
   assign M_AXI4_ARLOCK  = LOCK_DEFAULT;
   assign M_AXI4_ARCACHE = CACHE_DEFAULT;
   assign M_AXI4_ARPROT  = PROT_DEFAULT;
   assign M_AXI4_ARVALID = (rst_q == ST_BUSY);

   vxe_axi4mas_biu_resp #(.PW(CID_WIDTH + 2)) u_bresp (
      .clk_i       (M_AXI4_ACLK),
      .rst_i       (rst),
      .s_valid_i   (M_AXI4_BVALID),
      .s_payload_i ({bcid_conv, M_AXI4_BRESP}),
      .s_ready_o   (M_AXI4_BREADY),
      .c_ready_i   (biu_bready),
      .c_push_o    (biu_bpush),
      .c_payload_o ({biu_bcid, biu_bresp})
   );

   vxe_axi4mas_biu_resp #(.PW(CID_WIDTH + DATA_WIDTH + 2)) u_rresp (
      .clk_i       (M_AXI4_ACLK),
      .rst_i       (rst),
      .s_valid_i   (M_AXI4_RVALID),
      .s_payload_i ({rcid_conv, M_AXI4_RDATA, M_AXI4_RRESP}),
      .s_ready_o   (M_AXI4_RREADY),
      .c_ready_i   (biu_rready),
      .c_push_o    (biu_rpush),
      .c_payload_o ({biu_rcid, biu_rdata, biu_rresp})
   );

endmodule

// File: tb/tb_vxe_axi4mas_biu.sv
// Self-checking bench for vxe_axi4mas_biu in its default (pass-through response) build.
module tb_vxe_axi4mas_biu;

   localparam int AW = 32, DW = 32, IW = 8, CW = 8;
   localparam logic [2:0] EXP_SIZE = 3'($clog2(DW / 8));

   logic clk = 1'b0, rst;
   always #5 clk = ~clk;

   logic [IW-1:0] awid, arid, bid, rid;
   logic [AW-1:0] awaddr, araddr;
   logic [7:0] awlen, arlen;
   logic [2:0] awsize, arsize, awprot, arprot;
   logic [1:0] awburst, arburst, bresp, rresp;
   logic awlock, arlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rlast, rvalid, rready;
   logic [3:0] awcache, arcache;
   logic [DW-1:0] wdata, rdata;
   logic [DW/8-1:0] wstrb;
   logic [CW-1:0] q_awcid, q_arcid, o_bcid, o_rcid;
   logic [AW-1:0] q_awaddr, q_araddr;
   logic [DW-1:0] q_awdata, o_rdata;
   logic [DW/8-1:0] q_awstrb;
   logic q_awvalid, q_arvalid, awpop, arpop, c_bready, c_rready, bpush, rpush;
   logic [1:0] o_bresp, o_rresp;

   int unsigned errors = 0, checks = 0;

   vxe_axi4mas_biu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .CID_WIDTH(CW)) dut (
      .M_AXI4_ACLK(clk), .M_AXI4_ARESETn(rst),
      .M_AXI4_AWID(awid), .M_AXI4_AWADDR(awaddr), .M_AXI4_AWLEN(awlen), .M_AXI4_AWSIZE(awsize),
      .M_AXI4_AWBURST(awburst), .M_AXI4_AWLOCK(awlock), .M_AXI4_AWCACHE(awcache),
      .M_AXI4_AWPROT(awprot), .M_AXI4_AWVALID(awvalid), .M_AXI4_AWREADY(awready),
      .M_AXI4_WDATA(wdata), .M_AXI4_WSTRB(wstrb), .M_AXI4_WLAST(wlast), .M_AXI4_WVALID(wvalid),
      .M_AXI4_WREADY(wready), .M_AXI4_BID(bid), .M_AXI4_BRESP(bresp), .M_AXI4_BVALID(bvalid),
      .M_AXI4_BREADY(bready),
      .M_AXI4_ARID(arid), .M_AXI4_ARADDR(araddr), .M_AXI4_ARLEN(arlen), .M_AXI4_ARSIZE(arsize),
      .M_AXI4_ARBURST(arburst), .M_AXI4_ARLOCK(arlock), .M_AXI4_ARCACHE(arcache),
      .M_AXI4_ARPROT(arprot), .M_AXI4_ARVALID(arvalid), .M_AXI4_ARREADY(arready),
      .M_AXI4_RID(rid), .M_AXI4_RDATA(rdata), .M_AXI4_RRESP(rresp), .M_AXI4_RLAST(rlast),
      .M_AXI4_RVALID(rvalid), .M_AXI4_RREADY(rready),
      .biu_awcid(q_awcid), .biu_awaddr(q_awaddr), .biu_awdata(q_awdata), .biu_awstrb(q_awstrb),
      .biu_awvalid(q_awvalid), .biu_awpop(awpop), .biu_bcid(o_bcid), .biu_bresp(o_bresp),
      .biu_bready(c_bready), .biu_bpush(bpush),
      .biu_arcid(q_arcid), .biu_araddr(q_araddr), .biu_arvalid(q_arvalid), .biu_arpop(arpop),
      .biu_rcid(o_rcid), .biu_rdata(o_rdata), .biu_rresp(o_rresp), .biu_rready(c_rready),
      .biu_rpush(rpush)
   );

   // AXI IDs carry the client ID zero-extended or truncated to the other width.
   function automatic logic [IW-1:0] to_id(input logic [CW-1:0] c);
      return IW'(c);
   endfunction
   function automatic logic [CW-1:0] to_cid(input logic [IW-1:0] i);
      return CW'(i);
   endfunction

   task automatic idle_inputs();
      q_awvalid = 0; q_arvalid = 0; q_awcid = '0; q_awaddr = '0; q_awdata = '0; q_awstrb = '0;
      q_arcid = '0; q_araddr = '0; c_bready = 0; c_rready = 0;
      awready = 0; wready = 0; arready = 0;
      bvalid = 0; bid = '0; bresp = '0; rvalid = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1; q_awvalid = 1; q_arvalid = 1; bvalid = 1; rvalid = 1; c_bready = 1; c_rready = 1;
      awready = 1; wready = 1; arready = 1;
      @(negedge clk); #1;
      checks++;
      if ({awpop, arpop, bpush, rpush, bready, rready} !== 6'b0) begin
         errors++; $display("FAIL reset_strobes got=%b exp=000000", {awpop, arpop, bpush, rpush, bready, rready});
      end
      checks++;
      if ({awvalid, wvalid, arvalid} !== 3'b0) begin
         errors++; $display("FAIL reset_valids got=%b exp=000", {awvalid, wvalid, arvalid});
      end
      checks++;
      if ({awaddr, wdata, araddr, awid, arid} !== '0) begin
         errors++; $display("FAIL reset_regs addr=%h data=%h raddr=%h exp=0", awaddr, wdata, araddr);
      end
      @(negedge clk); idle_inputs(); rst = 0;
   endtask

   task automatic test_write(input logic [CW-1:0] cid, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input logic [DW/8-1:0] strb,
                             input int aw_stall, input int w_stall, input int b_stall,
                             input logic [1:0] resp);
      int n;
      n = (aw_stall > w_stall) ? aw_stall : w_stall;
      @(negedge clk);
      q_awcid = cid; q_awaddr = addr; q_awdata = data; q_awstrb = strb; q_awvalid = 1;
      awready = 0; wready = 0; #1;
      checks++;
      if ({awpop, awvalid, wvalid} !== 3'b100) begin
         errors++; $display("FAIL wr_pop pop/awv/wv got=%b exp=100", {awpop, awvalid, wvalid});
      end
      for (int c = 0; c <= n; c++) begin
         @(negedge clk);
         q_awcid = ~cid; q_awaddr = ~addr; q_awdata = ~data;
         awready = (c >= aw_stall); wready = (c >= w_stall); #1;
         checks++;
         if ({awpop, awvalid, wvalid, arvalid} !== {1'b0, c <= aw_stall, c <= w_stall, 1'b0}) begin
            errors++;
            $display("FAIL wr_busy c=%0d pop/awv/wv/arv got=%b exp=%b", c, {awpop, awvalid, wvalid, arvalid},
                     {1'b0, c <= aw_stall, c <= w_stall, 1'b0});
         end
         if (c == 0) begin
            checks++;
            if ({awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot} !==
                {to_id(cid), addr, 8'd0, EXP_SIZE, 2'b01, 1'b0, 4'b0, 3'b0}) begin
               errors++; $display("FAIL wr_aw_fields id=%h addr=%h len=%h size=%h burst=%b exp id=%h addr=%h",
                                  awid, awaddr, awlen, awsize, awburst, to_id(cid), addr);
            end
            checks++;
            if ({wdata, wstrb, wlast} !== {data, strb, 1'b1}) begin
               errors++; $display("FAIL wr_w_fields data=%h strb=%h last=%b exp %h %h 1", wdata, wstrb, wlast, data, strb);
            end
         end
      end
      @(negedge clk); q_awvalid = 0; awready = 0; wready = 0; #1;
      checks++;
      if ({awvalid, wvalid} !== 2'b00) begin
         errors++; $display("FAIL wr_done awv/wv got=%b exp=00", {awvalid, wvalid});
      end
      for (int k = 0; k < b_stall; k++) begin
         @(negedge clk); bvalid = 1; bid = to_id(cid); bresp = resp; c_bready = 0; #1;
         checks++;
         if ({bready, bpush} !== 2'b00) begin
            errors++; $display("FAIL b_hold k=%0d bready/bpush got=%b exp=00", k, {bready, bpush});
         end
      end
      @(negedge clk); bvalid = 1; bid = to_id(cid); bresp = resp; c_bready = 1; #1;
      checks++;
      if ({bready, bpush, o_bcid, o_bresp} !== {2'b11, to_cid(to_id(cid)), resp}) begin
         errors++; $display("FAIL b_push rdy/push=%b bcid=%h bresp=%b exp 11 %h %b",
                            {bready, bpush}, o_bcid, o_bresp, to_cid(to_id(cid)), resp);
      end
      @(negedge clk); bvalid = 0; #1;
      checks++;
      if (bpush !== 1'b0) begin
         errors++; $display("FAIL b_single bpush got=%b exp=0", bpush);
      end
      c_bready = 0;
   endtask

   task automatic test_read(input logic [CW-1:0] cid, input logic [AW-1:0] addr, input int ar_stall,
                            input int r_stall, input logic [DW-1:0] data, input logic [1:0] resp);
      @(negedge clk);
      q_arcid = cid; q_araddr = addr; q_arvalid = 1; arready = 0; #1;
      checks++;
      if ({arpop, arvalid} !== 2'b10) begin
         errors++; $display("FAIL rd_pop pop/arv got=%b exp=10", {arpop, arvalid});
      end
      for (int c = 0; c <= ar_stall; c++) begin
         @(negedge clk); q_arcid = ~cid; q_araddr = ~addr; arready = (c >= ar_stall); #1;
         checks++;
         if ({arpop, arvalid, awvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot} !==
             {2'b01, 1'b0, to_id(cid), addr, 8'd0, EXP_SIZE, 2'b01, 1'b0, 4'b0, 3'b0}) begin
            errors++; $display("FAIL rd_busy c=%0d pop/arv/awv=%b id=%h addr=%h size=%h burst=%b exp 010 %h %h",
                               c, {arpop, arvalid, awvalid}, arid, araddr, arsize, arburst, to_id(cid), addr);
         end
      end
      @(negedge clk); q_arvalid = 0; arready = 0; #1;
      checks++;
      if (arvalid !== 1'b0) begin
         errors++; $display("FAIL rd_done arvalid got=%b exp=0", arvalid);
      end
      for (int k = 0; k < r_stall; k++) begin
         @(negedge clk); rvalid = 1; rid = to_id(cid); rdata = data; rresp = resp; rlast = 1'($urandom);
         c_rready = 0; #1;
         checks++;
         if ({rready, rpush} !== 2'b00) begin
            errors++; $display("FAIL r_hold k=%0d rready/rpush got=%b exp=00", k, {rready, rpush});
         end
      end
      @(negedge clk); rvalid = 1; rid = to_id(cid); rdata = data; rresp = resp; rlast = 1'($urandom);
      c_rready = 1; #1;
      checks++;
      if ({rready, rpush, o_rcid, o_rdata, o_rresp} !== {2'b11, to_cid(to_id(cid)), data, resp}) begin
         errors++; $display("FAIL r_push rdy/push=%b rcid=%h rdata=%h rresp=%b exp 11 %h %h %b",
                            {rready, rpush}, o_rcid, o_rdata, o_rresp, to_cid(to_id(cid)), data, resp);
      end
      @(negedge clk); rvalid = 0; #1;
      checks++;
      if (rpush !== 1'b0) begin
         errors++; $display("FAIL r_single rpush got=%b exp=0", rpush);
      end
      c_rready = 0;
   endtask

   // With the queue always non-empty and the slave always ready, pops land every other cycle.
   task automatic test_back_to_back();
      @(negedge clk); awready = 1; wready = 1; q_awvalid = 1;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         q_awaddr = AW'($urandom); #1;
         checks++;
         if ({awpop, awvalid, wvalid} !== {c % 2 == 0, c % 2 == 1, c % 2 == 1}) begin
            errors++; $display("FAIL b2b c=%0d pop/awv/wv got=%b", c, {awpop, awvalid, wvalid});
         end
      end
      @(negedge clk); q_awvalid = 0; awready = 0; wready = 0;
   endtask

   task automatic test_parallel();
      logic [CW-1:0] wc, rc;
      logic [DW-1:0] d;
      wc = CW'($urandom); rc = CW'($urandom); d = DW'($urandom);
      @(negedge clk);
      q_awcid = wc; q_awvalid = 1; q_arcid = rc; q_arvalid = 1; awready = 1; wready = 1; arready = 1; #1;
      checks++;
      if ({awpop, arpop} !== 2'b11) begin
         errors++; $display("FAIL par_pops got=%b exp=11", {awpop, arpop});
      end
      @(negedge clk); q_awvalid = 0; q_arvalid = 0; #1;
      checks++;
      if ({awvalid, wvalid, arvalid, awid, arid} !== {3'b111, to_id(wc), to_id(rc)}) begin
         errors++; $display("FAIL par_valids got=%b ids=%h/%h exp 111 %h/%h",
                            {awvalid, wvalid, arvalid}, awid, arid, to_id(wc), to_id(rc));
      end
      @(negedge clk); awready = 0; wready = 0; arready = 0;
      bvalid = 1; bid = to_id(wc); rvalid = 1; rid = to_id(rc); rdata = d; c_bready = 1; c_rready = 1; #1;
      checks++;
      if ({bpush, rpush, o_bcid, o_rcid, o_rdata} !== {2'b11, to_cid(to_id(wc)), to_cid(to_id(rc)), d}) begin
         errors++; $display("FAIL par_resp push=%b bcid=%h rcid=%h rdata=%h", {bpush, rpush}, o_bcid, o_rcid, o_rdata);
      end
      @(negedge clk); bvalid = 0; rvalid = 0; c_bready = 0; c_rready = 0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk); q_awvalid = 1; q_awaddr = 32'h1234; awready = 0; wready = 0;
      @(negedge clk); #1;
      checks++;
      if ({awvalid, wvalid} !== 2'b11) begin
         errors++; $display("FAIL rm_busy awv/wv got=%b exp=11", {awvalid, wvalid});
      end
      rst = 1; bvalid = 1; c_bready = 1; #1;
      checks++;
      if ({awpop, bpush, bready} !== 3'b000) begin
         errors++; $display("FAIL rm_in_reset pop/push/bready got=%b exp=000", {awpop, bpush, bready});
      end
      @(negedge clk); #1;
      checks++;
      if ({awvalid, wvalid, awpop} !== 3'b000) begin
         errors++; $display("FAIL rm_abandon awv/wv/pop got=%b exp=000", {awvalid, wvalid, awpop});
      end
      rst = 0; q_awvalid = 0; bvalid = 0; c_bready = 0; awready = 1; wready = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         checks++;
         if ({awvalid, wvalid, awpop, bpush} !== 4'b0) begin
            errors++; $display("FAIL rm_no_reissue c=%0d got=%b exp=0000", c, {awvalid, wvalid, awpop, bpush});
         end
      end
      idle_inputs();
   endtask

   task automatic test_random();
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 1) == 1)
            test_write(CW'($urandom), AW'($urandom), DW'($urandom), (DW/8)'($urandom),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom));
         else
            test_read(CW'($urandom), AW'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                      DW'($urandom), 2'($urandom));
      end
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_write(8'hfe, 32'h0000000c, 32'hfefefafa, 4'hf, 0, 0, 0, 2'b00);
      test_read(8'hfa, 32'h0000000b, 0, 0, 32'hfefefafa, 2'b00);
      test_write(8'hfc, 32'h0000f00c, 32'hdededada, 4'hf, 0, 0, 4, 2'b00);
      test_read(8'hfd, 32'h0000f00b, 0, 4, 32'hdededada, 2'b00);
      test_write(8'h11, 32'h00000100, 32'h01234567, 4'h5, 3, 0, 0, 2'b10);
      test_back_to_back();
      test_parallel();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vxe_axi4mas_biu.md
# vxe_axi4mas_biu

AXI4 master bus interface unit for VxEngine. It converts single-word write and read requests from FIFO-style client queues into single-beat AXI4 transactions. It returns write and read responses, tagged with the client ID, into client response queues. It sits between the engine's memory request arbitration and the system AXI4 interconnect.

## Interface
Parameters:
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width, power of two ≥ 8.
- ID_WIDTH, 8: AXI ID width.
- CID_WIDTH, 8: client ID width.

Ports:
- M_AXI4_ACLK  in  1  sole clock.
- M_AXI4_ARESETn  in  1  reset. Synchronous and active-high (1 = reset); the name is kept for codebase compatibility.
- M_AXI4_AW{ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,VALID}  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/1  AXI write address channel.
- M_AXI4_AWREADY  in  1.
- M_AXI4_W{DATA,STRB,LAST,VALID}  out  DATA_WIDTH/DATA_WIDTH/8/1/1  AXI write data channel.
- M_AXI4_WREADY  in  1.
- M_AXI4_B{ID,RESP,VALID}  in  ID_WIDTH/2/1  AXI write response channel.
- M_AXI4_BREADY  out  1.
- M_AXI4_AR{ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,VALID}  out  same widths as AW  AXI read address channel.
- M_AXI4_ARREADY  in  1.
- M_AXI4_R{ID,DATA,RESP,LAST,VALID}  in  ID_WIDTH/DATA_WIDTH/2/1/1  AXI read data channel.
- M_AXI4_RREADY  out  1.
- biu_aw{cid,addr,data,strb}  in  CID_WIDTH/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  head of the write request queue.
- biu_awvalid  in  1  write queue not empty.
- biu_awpop  out  1  one-cycle pulse that removes the write request at the queue head.
- biu_bcid, biu_bresp  out  CID_WIDTH/2  write response.
- biu_bready  in  1  write response queue not full.
- biu_bpush  out  1  write response push strobe.
- biu_arcid, biu_araddr, biu_arvalid  in  read request queue head.
- biu_arpop  out  1  read request pop strobe.
- biu_rcid, biu_rdata, biu_rresp  out  read response.
- biu_rready  in  1  read response queue not full.
- biu_rpush  out  1  read response push strobe.

## Operation
- The write and read request paths are independent. Each has a two-state FSM: IDLE and BUSY.
- Write path in IDLE with biu_awvalid=1:
  - Pulse biu_awpop in the same cycle.
  - Latch cid, addr, data and strb.
  - Move to BUSY.
- Write path in BUSY:
  - Assert AWVALID and WVALID together.
  - Drop each VALID independently on its own handshake.
  - Return to IDLE when both the AW and W handshakes are done.
  - The queue is not sampled while BUSY.
- Read path: same FSM, using AR only.
- Fixed AXI fields:
  - LEN=0.
  - SIZE=log2(DATA_WIDTH/8).
  - BURST=2'b01 (INCR).
  - LOCK=0, CACHE=4'b0000, PROT=3'b000.
  - WLAST=1.
- AWID/ARID = cid, zero-extended or truncated to ID_WIDTH. biu_bcid/biu_rcid = BID/RID, converted the same way.
- Responses pass through:
  - BREADY=biu_bready and biu_bpush=BVALID&biu_bready.
  - RREADY=biu_rready and biu_rpush=RVALID&biu_rready.
  - RLAST is ignored.
- Writes and reads may have any number of responses outstanding; the block keeps no ordering state.

## Timing
- During reset: all VALIDs, pops, pushes, BREADY and RREADY are 0; latched request registers are 0.
- Latency from request to AXI VALID is 1 cycle (pop in cycle N, AW/W/AR VALID in cycle N+1).
- Minimum request spacing is 2 cycles when the slave is always ready.
- Response latency is 0 cycles, combinational, when the configuration macro is undefined.
- With biu_bready=0 or biu_rready=0, the slave's VALID is held off indefinitely. No push occurs until the matching ready rises.
- Reset asserted mid-transaction abandons it; the request is not re-issued after reset.

## Configuration
- VXE_AXI4MAS_BIU_RESP_REG_EN defined:
  - The B and R paths each get a one-entry response register.
  - BREADY/RREADY = register empty.
  - Push is driven from the register when the client ready is 1.
  - Adds 1 cycle of latency and removes the combinational ready/valid path.
- Undefined: combinational pass-through as described in Operation.

## Structure
- Shared package vxe_axi4mas_pkg holds:
  - AXI constants: BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR, LOCK/CACHE/PROT defaults.
  - A SIZE-from-DATA_WIDTH function.
- One sub-module, vxe_axi4mas_biu_resp: the response path (pass-through or registered), instantiated for B and for R.

## Test plan
- Write cid=0xfe, addr=0x0000000c, data=0xfefefafa, biu_bready=1:
  - one awpop pulse;
  - AWID=0xfe, AWADDR=0xc, WDATA=0xfefefafa, LEN=0, BURST=01, WLAST=1;
  - bpush with bcid=0xfe, bresp=00.
- Read cid=0xfa, addr=0x0000000b, biu_rready=1:
  - arpop pulse;
  - ARID=0xfa, ARADDR=0xb;
  - rpush with rcid=0xfa, rdata equal to the slave data (0xfefefafa).
- Write cid=0xfc, addr=0xf00c, data=0xdededada, biu_bready=0:
  - BREADY stays 0 and there is no bpush;
  - when biu_bready rises, exactly one bpush with bcid=0xfc.
- Read cid=0xfd, addr=0xf00b, biu_rready=0:
  - no rpush;
  - after biu_rready rises, one rpush with rcid=0xfd and rdata=0xdededada.
- AWREADY held 0 for 3 cycles while WREADY=1:
  - WVALID drops after 1 cycle;
  - AWVALID holds for 3 cycles;
  - the FSM returns to IDLE only after the AW handshake.
- Reset asserted while the write FSM is BUSY: AWVALID=WVALID=0 on the next cycle and no late pop or push.
